// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/response bundle for alu_pipe.
// The master drives requests and consumes results; the slave (the ALU) answers.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;
   logic             illegal;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carryout, overflow, zero, illegal
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carryout, overflow, zero, illegal
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: single-slot ALU with valid/ready on both sides.
// Ops 0-7 finish in one cycle; op 8 (MUL) is an iterative shift-add multiplier that is
// only present when the macro ALU_PIPE_MUL_EN is defined. Without it op 8 is illegal.
module alu_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   alu_pipe_if.slave bus
);

   localparam int unsigned Msb = WIDTH - 1;

`ifdef ALU_PIPE_MUL_EN
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StFull = 2'd1,
      StMul  = 2'd2
   } state_e;
`else
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StFull = 2'd1
   } state_e;
`endif

   state_e state_q, state_d;

   // Held result and flags
   logic [WIDTH-1:0] res_q, res_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;
   logic             z_q, z_d;
   logic             il_q, il_d;

   // Single-cycle ALU outputs
   logic [WIDTH-1:0] alu_res;
   logic             alu_co;
   logic             alu_ov;
   logic             alu_il;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic             slt;

   logic             in_ready;
   logic             out_valid;
   logic             accept;

`ifdef ALU_PIPE_MUL_EN
   // prod holds {partial sum, remaining multiplier bits}; it shifts right once per step
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic               mul_last;
   logic               is_mul;
`endif

   // Combinational single-cycle operations on the incoming request
   always_comb begin
      alu_res  = '0;
      alu_co   = 1'b0;
      alu_ov   = 1'b0;
      alu_il   = 1'b0;
      add_full = {1'b0, bus.a} + {1'b0, bus.b};
      sub_full = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
      slt      = $signed(bus.a) < $signed(bus.b);
      case (bus.op)
         4'd0: begin
            alu_res = add_full[WIDTH-1:0];
            alu_co  = add_full[WIDTH];
            alu_ov  = (bus.a[Msb] == bus.b[Msb]) && (add_full[Msb] != bus.a[Msb]);
         end
         4'd1: begin
            alu_res = sub_full[WIDTH-1:0];
            // Report a borrow: 1 when a < b unsigned
            alu_co  = ~sub_full[WIDTH];
            alu_ov  = (bus.a[Msb] != bus.b[Msb]) && (sub_full[Msb] != bus.a[Msb]);
         end
         4'd2: alu_res = bus.a ^ bus.b;
         4'd3: alu_res = {{(WIDTH-1){1'b0}}, slt};
         4'd4: alu_res = bus.a & bus.b;
         4'd5: alu_res = ~(bus.a & bus.b);
         4'd6: alu_res = ~(bus.a | bus.b);
         4'd7: alu_res = bus.a | bus.b;
         // op 8 is taken by the multiplier FSM path when it is built in
         default: alu_il = 1'b1;
      endcase
   end

`ifdef ALU_PIPE_MUL_EN
   // One shift-add multiplier step
   always_comb begin
      is_mul   = (bus.op == 4'd8);
      mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      mul_next = {mul_sum, prod_q[WIDTH-1:1]};
      mul_last = (cnt_q == CntW'(WIDTH - 1));
   end
`endif

   // Next-state, handshake outputs and result loading
   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      co_d      = co_q;
      ov_d      = ov_q;
      z_d       = z_q;
      il_d      = il_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef ALU_PIPE_MUL_EN
      prod_d    = prod_q;
      mcand_d   = mcand_q;
      cnt_d     = cnt_q;
`endif
      case (state_q)
         StIdle: in_ready = 1'b1;
         StFull: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
            if (bus.out_ready && !bus.in_valid) begin
               state_d = StIdle;
            end
         end
`ifdef ALU_PIPE_MUL_EN
         StMul: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + CntW'(1);
            if (mul_last) begin
               state_d = StFull;
               res_d   = mul_next[WIDTH-1:0];
               co_d    = |mul_next[2*WIDTH-1:WIDTH];
               ov_d    = 1'b0;
               z_d     = (mul_next[WIDTH-1:0] == '0);
               il_d    = 1'b0;
            end
         end
`endif
         default: state_d = StIdle;
      endcase

      accept = bus.in_valid && in_ready;
      if (accept) begin
`ifdef ALU_PIPE_MUL_EN
         if (is_mul) begin
            state_d = StMul;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            mcand_d = bus.a;
            cnt_d   = '0;
         end else begin
            state_d = StFull;
            res_d   = alu_res;
            co_d    = alu_co;
            ov_d    = alu_ov;
            z_d     = (alu_res == '0);
            il_d    = alu_il;
         end
`else
         state_d = StFull;
         res_d   = alu_res;
         co_d    = alu_co;
         ov_d    = alu_ov;
         z_d     = (alu_res == '0);
         il_d    = alu_il;
`endif
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         res_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         z_q     <= 1'b0;
         il_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         prod_q  <= '0;
         mcand_q <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         z_q     <= z_d;
         il_q    <= il_d;
`ifdef ALU_PIPE_MUL_EN
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.result    = res_q;
   assign bus.carryout  = co_q;
   assign bus.overflow  = ov_q;
   assign bus.zero      = z_q;
   assign bus.illegal   = il_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32), directed corner cases
// followed by randomized traffic with random back-pressure.
module tb_alu_pipe;

   localparam int unsigned W = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   alu_pipe_if #(.WIDTH(W)) bus_if ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic        c;
      logic        o;
      logic        z;
      logic        il;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Abstract timing model: a result slot, and cycles left before a multiply finishes
   bit   m_hold     = 1'b0;
   int   m_mul_left = 0;

   function automatic exp_t mk(logic [31:0] res, logic c, logic o, logic z, logic il);
      exp_t e;
      e.res = res;
      e.c   = c;
      e.o   = o;
      e.z   = z;
      e.il  = il;
      return e;
   endfunction

   function automatic bit is_mul_op(logic [3:0] op);
`ifdef ALU_PIPE_MUL_EN
      return op == 4'd8;
`else
      return 1'b0;
`endif
   endfunction

   // Reference model from the arithmetic definitions of each op
   function automatic exp_t ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
      exp_t        e;
      longint      sa;
      longint      sb;
      longint      s;
      logic [63:0] p;
      e  = '0;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         4'd0: begin
            e.res = a + b;
            e.c   = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            s     = sa + sb;
            e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd1: begin
            e.res = a - b;
            e.c   = a < b;
            s     = sa - sb;
            e.o   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd2: e.res = a ^ b;
         4'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'd4: e.res = a & b;
         4'd5: e.res = ~(a & b);
         4'd6: e.res = ~(a | b);
         4'd7: e.res = a | b;
         4'd8: begin
`ifdef ALU_PIPE_MUL_EN
            p     = 64'(a) * 64'(b);
            e.res = p[31:0];
            e.c   = p[63:32] != 32'd0;
`else
            p     = '0;
            e.il  = 1'b1;
`endif
         end
         default: e.il = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   // Compare current visible outputs with constants
   task automatic expect_out(input string name, input exp_t want);
      exp_t got;
      got = mk(bus_if.result, bus_if.carryout, bus_if.overflow, bus_if.zero, bus_if.illegal);
      check1({name, "_valid"}, 64'(bus_if.out_valid), 64'd1);
      check1(name, 64'(got), 64'(want));
   endtask

   // One clock of stimulus; checks handshake timing against the model
   task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input bit ordy, output bit acc);
      bit e_ir;
      bit e_ov;
      @(negedge clk);
      bus_if.in_valid  = v;
      bus_if.a         = a;
      bus_if.b         = b;
      bus_if.op        = op;
      bus_if.out_ready = ordy;
      #1;
      e_ov = m_hold && (m_mul_left == 0);
      e_ir = (m_mul_left == 0) && (!m_hold || ordy);
      check1("in_ready", 64'(bus_if.in_ready), 64'(e_ir));
      check1("out_valid", 64'(bus_if.out_valid), 64'(e_ov));
      acc = v && e_ir;
      if (acc) exp_q.push_back(ref_alu(a, b, op));
      if (m_mul_left > 0) m_mul_left--;
      if (acc) begin
         m_hold     = 1'b1;
         m_mul_left = is_mul_op(op) ? int'(W) : 0;
      end else if (e_ov && ordy) begin
         m_hold = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset            = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      exp_q.delete();
      m_hold           = 1'b0;
      m_mul_left       = 0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check1("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
      check1("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check1("rst_result", 64'(bus_if.result), 64'd0);
      check1("rst_flags", 64'({bus_if.carryout, bus_if.overflow, bus_if.zero, bus_if.illegal}),
             64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every visible result must match the oldest pending expectation
   initial begin
      exp_t got;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && bus_if.out_valid) begin
            got = mk(bus_if.result, bus_if.carryout, bus_if.overflow, bus_if.zero,
                     bus_if.illegal);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_out: out_valid=1 with nothing pending, result=%0h",
                        got.res);
            end else begin
               n_vec++;
               if (got !== exp_q[0]) begin
                  n_fail++;
                  $display("FAIL scoreboard: got res=%0h c=%0b o=%0b z=%0b il=%0b, expected res=%0h c=%0b o=%0b z=%0b il=%0b",
                           got.res, got.c, got.o, got.z, got.il, exp_q[0].res, exp_q[0].c,
                           exp_q[0].o, exp_q[0].z, exp_q[0].il);
               end
               if (bus_if.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      bit          acc;
      bit          have;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [3:0]  rop;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.op        = '0;
      bus_if.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // Signed overflow on ADD
      cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd0, 1'b1, acc);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("add_ovf", mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0));

      // Back-to-back SUB then SLT
      cycle(1'b1, 32'h1234_5678, 32'h1234_5678, 4'd1, 1'b1, acc);
      cycle(1'b1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'd3, 1'b1, acc);
      expect_out("sub_eq", mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b0));
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("slt_neg", mk(32'h1, 1'b0, 1'b0, 1'b0, 1'b0));

      // SUB borrow
      cycle(1'b1, 32'h0000_0001, 32'h0000_0002, 4'd1, 1'b1, acc);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("sub_borrow", mk(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));

      // Illegal opcode
      cycle(1'b1, $urandom, $urandom, 4'hF, 1'b1, acc);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("illegal_f", mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1));

      // Hold under back-pressure, then consume and accept on the same edge
      cycle(1'b1, 32'h0000_00F0, 32'h0000_0F00, 4'd7, 1'b0, acc);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, '0, '0, 4'd0, 1'b0, acc);
         expect_out("or_hold", mk(32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      cycle(1'b1, 32'h0000_0005, 32'h0000_0006, 4'd0, 1'b1, acc);
      check1("same_edge_accept", 64'(acc), 64'd1);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("add_after_hold", mk(32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0));

      // Multiply
      cycle(1'b1, 32'h0000_0010, 32'h0000_0011, 4'd8, 1'b1, acc);
`ifdef ALU_PIPE_MUL_EN
      repeat (W) cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("mul_small", mk(32'h0000_0110, 1'b0, 1'b0, 1'b0, 1'b0));
`else
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("mul_illegal", mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
`endif
      cycle(1'b1, 32'hFFFF_FFFF, 32'h0000_0003, 4'd8, 1'b1, acc);
`ifdef ALU_PIPE_MUL_EN
      repeat (W) cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("mul_carry", mk(32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0, 1'b0));
`else
      cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      expect_out("mul_illegal2", mk(32'h0, 1'b0, 1'b0, 1'b1, 1'b1));
`endif

      // Reset while an operation is pending: nothing may come out afterwards
      cycle(1'b1, $urandom, $urandom, 4'd8, 1'b0, acc);
      repeat (3) cycle(1'b0, '0, '0, 4'd0, 1'b0, acc);
      do_reset();
      repeat (W + 4) cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);

      // Random traffic with random back-pressure
      have = 1'b0;
      ra   = '0;
      rb   = '0;
      rop  = '0;
      for (int i = 0; i < 1500; i++) begin
         if (!have && ($urandom_range(0, 2) != 0)) begin
            have = 1'b1;
            ra   = pick();
            rb   = pick();
            rop  = 4'($urandom_range(0, 15));
         end
         cycle(have, ra, rb, rop, ($urandom_range(0, 3) != 0), acc);
         if (acc) have = 1'b0;
      end

      // Drain
      repeat (W + 8) cycle(1'b0, '0, '0, 4'd0, 1'b1, acc);
      check1("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits (legal range 2..64).
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate a, b, op carry a valid request.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-006 a, b  input  WIDTH each  SHALL be the operands.
REQ-007 op  input  4  SHALL select: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR, 8 MUL, 9-15 illegal.
REQ-008 out_valid  output  1  SHALL indicate result/flags are valid.
REQ-009 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-010 result  output  WIDTH  SHALL be the operation result.
REQ-011 carryout, overflow, zero, illegal  output  1 each  SHALL be the result flags.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a result SHALL be consumed where out_valid and out_ready are both 1.
REQ-013 FSM states SHALL be IDLE (output empty), FULL (result held), MUL (multiply iterating).
REQ-014 in_ready SHALL be 1 in IDLE, equal out_ready in FULL, 0 in MUL.
REQ-015 Ops 0-7 and illegal ops SHALL complete in one cycle: accepted at edge k -> out_valid=1 after edge k, state FULL.
REQ-016 MUL SHALL be iterative shift-add, one multiplier bit per cycle: accepted at edge k -> state MUL, out_valid=1 after edge k+WIDTH, state FULL.
REQ-017 FULL with consume and no accept SHALL go to IDLE; FULL with simultaneous consume and accept SHALL load the new single-cycle result (stay FULL) or enter MUL.
REQ-018 result, flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 ADD/SUB SHALL be WIDTH-bit two's complement; carryout = carry out of MSB (SUB computed a+~b+1, carryout reported as borrow-free carry inverted, i.e. 1 when a<b unsigned); overflow = signed overflow.
REQ-020 SLT SHALL return 1 when a<b signed (correct across overflow), else 0, zero-extended.
REQ-021 Logic ops SHALL be bitwise; carryout=overflow=0 for logic ops and SLT.
REQ-022 MUL SHALL return low WIDTH bits of unsigned a*b; carryout=1 when high WIDTH bits are nonzero; overflow=0.
REQ-023 zero SHALL be 1 exactly when result is all zeros, for every op.
REQ-024 Illegal op SHALL give result 0, carryout=overflow=0, zero=1, illegal=1; illegal=0 otherwise.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, in_ready=1 next cycle, out_valid=0, result=0, all flags 0, MUL counter 0.
REQ-026 reset during MUL or FULL SHALL discard the pending operation with no output produced.

Configuration
REQ-027 Macro ALU_PIPE_MUL_EN defined SHALL compile in the MUL datapath, counter and MUL state.
REQ-028 Without ALU_PIPE_MUL_EN, op 8 SHALL be treated as illegal (REQ-024) and the MUL state SHALL not exist.

Verification
REQ-029 WIDTH=32, ADD a=7FFFFFFF b=7FFFFFFF, out_ready=1 -> next cycle out_valid=1, result=FFFFFFFE, overflow=1, carryout=0, zero=0.
REQ-030 WIDTH=32, SUB a=12345678 b=12345678 then SLT a=FFFFFFFF b=7FFFFFFF back-to-back with out_ready=1 -> result 0 zero=1, then result 1 zero=0; one result per cycle, in_ready held 1.
REQ-031 WIDTH=8 with ALU_PIPE_MUL_EN, MUL a=10 b=11 -> in_ready=0 for 8 cycles, then result=0x10, carryout=1; without macro -> next cycle illegal=1, result=0.
REQ-032 WIDTH=16, OR a=00F0 b=0F00 with out_ready=0 for 5 cycles -> result 0FF0 held stable, in_ready=0 until out_ready=1; simultaneous consume+new request accepted same edge.
REQ-033 reset asserted 3 cycles into a WIDTH=32 MUL -> next cycle out_valid=0, in_ready=1, result=0; no stale result ever appears.
REQ-034 op=0xF any operands -> result 0, zero=1, illegal=1, carryout=overflow=0.
